// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade driver.
package led_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } led_state_e;

  localparam int PRESC_BITS = 16;

  // Full-brightness duty value for a given PWM width.
  function automatic int duty_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM counter with a registered compare output.
module led_pwm_core #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                out
);
  import led_pkg::*;

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));

  logic [PWM_BITS-1:0] cnt_q;
  logic                out_q, out_d;

  // Full scale forces a solid high; otherwise compare against the live duty.
  always_comb begin
    out_d = (duty == DUTY_MAX) ? 1'b1 : (cnt_q < duty);
  end

  // Counter wraps naturally at 2^PWM_BITS; output registered one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/led_fade_driver.sv
// Turns a slow on/off level into linear brightness ramps rendered as PWM.
module led_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                level_in,
  output logic                out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);
  import led_pkg::*;

  localparam logic [PWM_BITS-1:0]   DUTY_MAX  = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PRESC_BITS-1:0] STEP_LAST = PRESC_BITS'(STEP_DIV - 1);

  logic                  s1_q, s2_q;
  led_state_e            state_q, state_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic                  lvl, tick;
  logic [PWM_BITS-1:0]   duty_inc, duty_dec;

  assign lvl      = s2_q;
  assign tick     = (presc_q == STEP_LAST);
  assign duty_inc = duty_q + PWM_BITS'(1);
  assign duty_dec = duty_q - PWM_BITS'(1);

  // Two-flop synchronizer for the asynchronous blinker level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= level_in;
      s2_q <= s1_q;
    end
  end

  // Ramp FSM: reversals keep duty and restart the step prescaler.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    presc_d = '0;
    unique case (state_q)
      OFF: begin
        if (lvl) state_d = RISE;
      end
      RISE: begin
        if (!lvl) begin
          state_d = FALL;
        end else if (tick) begin
          duty_d = duty_inc;
          if (duty_inc == DUTY_MAX) state_d = ON;
        end else begin
          presc_d = presc_q + PRESC_BITS'(1);
        end
      end
      ON: begin
        if (!lvl) state_d = FALL;
      end
      FALL: begin
        if (lvl) begin
          state_d = RISE;
        end else if (tick) begin
          duty_d = duty_dec;
          if (duty_dec == '0) state_d = OFF;
        end else begin
          presc_d = presc_q + PRESC_BITS'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  // FSM, duty and prescaler state; reset aborts any ramp at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      duty_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
    end
  end

  assign duty = duty_q;
  assign busy = (state_q == RISE) || (state_q == FALL);

  led_pwm_core #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk  (clk),
    .rst  (rst),
    .duty (duty_q),
    .out  (out)
  );

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench: per-cycle expectations derived from ramp timing formulas.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       level_in = 1'b0;
  logic       out0, out1, out2;
  logic [3:0] duty0, duty1, duty2;
  logic       busy0, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int duty;
    int busy;
    int out;   // -1 = not checked this cycle
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Main DUT: STEP_DIV=4.
  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .level_in(level_in),
    .out(out0), .duty(duty0), .busy(busy0)
  );
  // Fast ramp: STEP_DIV=1.
  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(1)) dut_fast (
    .clk(clk), .rst(rst), .level_in(level_in),
    .out(out1), .duty(duty1), .busy(busy1)
  );
  // Slow ramp holds each duty value long enough to measure the PWM.
  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(200)) dut_slow (
    .clk(clk), .rst(rst), .level_in(level_in),
    .out(out2), .duty(duty2), .busy(busy2)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the second reset edge (call it P0).
  task automatic do_reset();
    rst = 1'b1;
    level_in = 1'b0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    for (int j = 1; j <= 100; j++) begin
      adv();
      e.duty = 0; e.busy = 0; e.out = 0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (duty0 !== 4'(e.duty)) begin n_fail++; $display("FAIL reset_duty j=%0d got %0d exp %0d", j, duty0, e.duty); end
      n_checks++;
      if (busy0 !== 1'(e.busy)) begin n_fail++; $display("FAIL reset_busy j=%0d got %b exp %0d", j, busy0, e.busy); end
      n_checks++;
      if (out0 !== 1'(e.out)) begin n_fail++; $display("FAIL reset_out j=%0d got %b exp %0d", j, out0, e.out); end
    end
  endtask

  // Level rises after P0: RISE at P3, duty n at P3+4n, ON at P63.
  task automatic test_rise();
    exp_t e;
    int   d;
    do_reset();
    level_in = 1'b1;
    for (int j = 1; j <= 75; j++) begin
      adv();
      d = (j < 3) ? 0 : (j - 3) / 4;
      if (d > 15) d = 15;
      e.duty = d;
      e.busy = (j >= 3 && j < 63) ? 1 : 0;
      e.out  = (j >= 64) ? 1 : -1;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (duty0 !== 4'(e.duty)) begin n_fail++; $display("FAIL rise_duty j=%0d got %0d exp %0d", j, duty0, e.duty); end
      n_checks++;
      if (busy0 !== 1'(e.busy)) begin n_fail++; $display("FAIL rise_busy j=%0d got %b exp %0d", j, busy0, e.busy); end
      if (e.out >= 0) begin
        n_checks++;
        if (out0 !== 1'(e.out)) begin n_fail++; $display("FAIL rise_out j=%0d got %b exp %0d", j, out0, e.out); end
      end
    end
  endtask

  // Slow DUT sits at duty=5 from P1003 to P1203; out must be high 5 of every 16.
  task automatic test_pwm_duty5();
    exp_t e;
    int   highs;
    do_reset();
    level_in = 1'b1;
    for (int j = 1; j < 1010; j++) adv();
    for (int w = 0; w < 6; w++) begin
      e.duty = 5; e.busy = 1; e.out = -1;
      highs = 0;
      for (int c = 0; c < 16; c++) begin
        adv();
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (duty2 !== 4'(e.duty)) begin n_fail++; $display("FAIL pwm5_duty w=%0d c=%0d got %0d exp %0d", w, c, duty2, e.duty); end
        if (out2 === 1'b1) highs++;
      end
      n_checks++;
      if (highs !== 5) begin n_fail++; $display("FAIL pwm5_highs w=%0d got %0d exp 5", w, highs); end
    end
  endtask

  // Rise to 7 (P31), drop level -> FALL at P34, duty 0 and OFF at P62.
  task automatic test_reverse_fall();
    exp_t e;
    int   d;
    do_reset();
    level_in = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      adv();
      if (j == 31) level_in = 1'b0;
      if (j < 3) begin
        d = 0; e.busy = 0;
      end else if (j < 34) begin
        d = (j - 3) / 4;
        if (d > 7) d = 7;
        e.busy = 1;
      end else begin
        d = 7 - (j - 34) / 4;
        if (d < 0) d = 0;
        e.busy = (j < 62) ? 1 : 0;
      end
      e.duty = d;
      e.out  = (j >= 63) ? 0 : -1;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (duty0 !== 4'(e.duty)) begin n_fail++; $display("FAIL fall_duty j=%0d got %0d exp %0d", j, duty0, e.duty); end
      n_checks++;
      if (busy0 !== 1'(e.busy)) begin n_fail++; $display("FAIL fall_busy j=%0d got %b exp %0d", j, busy0, e.busy); end
      if (e.out >= 0) begin
        n_checks++;
        if (out0 !== 1'(e.out)) begin n_fail++; $display("FAIL fall_out j=%0d got %b exp %0d", j, out0, e.out); end
      end
    end
  endtask

  // rst at P41 while duty=9; ramp restarts with RISE at P44.
  task automatic test_reset_mid_ramp();
    exp_t e;
    int   k;
    do_reset();
    level_in = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      adv();
      if (j == 40) rst = 1'b1;
      if (j == 41) rst = 1'b0;
      k = (j < 41) ? j : j - 41;
      e.duty = (k < 3) ? 0 : (k - 3) / 4;
      e.busy = (k >= 3) ? 1 : 0;
      e.out  = (j == 41) ? 0 : -1;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (duty0 !== 4'(e.duty)) begin n_fail++; $display("FAIL rstmid_duty j=%0d got %0d exp %0d", j, duty0, e.duty); end
      n_checks++;
      if (busy0 !== 1'(e.busy)) begin n_fail++; $display("FAIL rstmid_busy j=%0d got %b exp %0d", j, busy0, e.busy); end
      if (e.out >= 0) begin
        n_checks++;
        if (out0 !== 1'(e.out)) begin n_fail++; $display("FAIL rstmid_out j=%0d got %b exp %0d", j, out0, e.out); end
      end
    end
  endtask

  // STEP_DIV=1: duty=j-3 up to 15 at P18; drop level -> FALL at P23, 0 at P38.
  task automatic test_fast_step();
    exp_t e;
    int   d;
    do_reset();
    level_in = 1'b1;
    for (int j = 1; j <= 45; j++) begin
      adv();
      if (j == 20) level_in = 1'b0;
      if (j < 3) begin
        d = 0; e.busy = 0;
      end else if (j < 23) begin
        d = j - 3;
        if (d > 15) d = 15;
        e.busy = (j < 18) ? 1 : 0;
      end else begin
        d = 15 - (j - 23);
        if (d < 0) d = 0;
        e.busy = (j < 38) ? 1 : 0;
      end
      e.duty = d;
      e.out  = (j >= 19 && j <= 23) ? 1 : ((j >= 39) ? 0 : -1);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (duty1 !== 4'(e.duty)) begin n_fail++; $display("FAIL fast_duty j=%0d got %0d exp %0d", j, duty1, e.duty); end
      n_checks++;
      if (busy1 !== 1'(e.busy)) begin n_fail++; $display("FAIL fast_busy j=%0d got %b exp %0d", j, busy1, e.busy); end
      if (e.out >= 0) begin
        n_checks++;
        if (out1 !== 1'(e.out)) begin n_fail++; $display("FAIL fast_out j=%0d got %b exp %0d", j, out1, e.out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_pwm_duty5();
    test_reverse_fall();
    test_reset_mid_ramp();
    test_fast_step();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
